// File: rtl/pattern_event_counter_pkg.sv
// Shared constants for the pattern detector / event counter pair: detector output
// codes and the snapshot FSM state encoding.
package pattern_event_counter_pkg;

    localparam logic [1:0] PAT_NONE    = 2'b00;
    localparam logic [1:0] PAT_010     = 2'b01;
    localparam logic [1:0] PAT_101     = 2'b10;
    localparam logic [1:0] PAT_ILLEGAL = 2'b11;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HOLD = 1'b1
    } pec_state_e;

endpackage

// File: rtl/event_counter.sv
// Single live event counter with clear-and-count priority.
// PEC_SATURATE_EN defined: holds at all-ones; otherwise wraps modulo 2^CNT_W.
module event_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // A clear coinciding with an event keeps that event, so the counter restarts at 1.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = inc ? CNT_W'(1) : '0;
        end else if (inc) begin
`ifdef PEC_SATURATE_EN
            if (count_q != '1) begin
                count_d = count_q + CNT_W'(1);
            end
`else
            count_d = count_q + CNT_W'(1);
`endif
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pattern_event_counter.sv
// Counts 101/010 detector events, flags illegal codes, and offers a req/ack snapshot
// of both counts. Build option PEC_SATURATE_EN selects saturating counters.
module pattern_event_counter
    import pattern_event_counter_pkg::*;
#(
    parameter int CNT_W     = 8,
    parameter int THRESHOLD = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [1:0]       pattern,
    input  logic             snap_req,
    input  logic             snap_ack,
    output logic             snap_valid,
    output logic [CNT_W-1:0] snap101,
    output logic [CNT_W-1:0] snap010,
    output logic             alert,
    output logic             err
);

    localparam logic [CNT_W:0] THRESH = (CNT_W + 1)'(THRESHOLD);

    logic [1:0]       cap_q;
    pec_state_e       state_q;
    pec_state_e       state_d;
    logic             snap_load;
    logic             live_clr;
    logic             err_q;
    logic [CNT_W-1:0] snap101_q;
    logic [CNT_W-1:0] snap010_q;
    logic [CNT_W-1:0] live101;
    logic [CNT_W-1:0] live010;
    logic [CNT_W:0]   live_sum;

    // The detector only holds pattern stable from falling to rising edge.
    always_ff @(negedge clock) begin
        if (reset) begin
            cap_q <= PAT_NONE;
        end else begin
            cap_q <= pattern;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:  if (snap_req) state_d = ST_HOLD;
            ST_HOLD: if (snap_ack) state_d = ST_RUN;
            default: state_d = ST_RUN;
        endcase
    end

    always_comb begin
        snap_valid = (state_q == ST_HOLD);
        snap_load  = (state_q == ST_RUN) && snap_req;
        live_clr   = (state_q == ST_HOLD) && snap_ack;
    end

    // Snapshot takes the counts as they stood before this edge's increment.
    always_ff @(posedge clock) begin
        if (reset) begin
            snap101_q <= '0;
            snap010_q <= '0;
        end else if (snap_load) begin
            snap101_q <= live101;
            snap010_q <= live010;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (cap_q == PAT_ILLEGAL) begin
            err_q <= 1'b1;
        end
    end

    event_counter #(.CNT_W(CNT_W)) u_cnt101 (
        .clock (clock),
        .reset (reset),
        .inc   (cap_q == PAT_101),
        .clr   (live_clr),
        .count (live101)
    );

    event_counter #(.CNT_W(CNT_W)) u_cnt010 (
        .clock (clock),
        .reset (reset),
        .inc   (cap_q == PAT_010),
        .clr   (live_clr),
        .count (live010)
    );

    // Decoded straight from the counter flops, so alert moves on the same edge as the counts.
    assign live_sum = {1'b0, live101} + {1'b0, live010};
    assign alert    = (live_sum >= THRESH);
    assign snap101  = snap101_q;
    assign snap010  = snap010_q;
    assign err      = err_q;

endmodule

// File: tb/tb_pattern_event_counter.sv
// Bench for pattern_event_counter: directed scenarios followed by random traffic,
// all checked against a behavioural model of the counting/snapshot rules.
module tb_pattern_event_counter;
    import pattern_event_counter_pkg::*;

    localparam int CNT_W     = 8;
    localparam int THRESHOLD = 4;
    localparam int CMAX      = (1 << CNT_W) - 1;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic [1:0]       pattern = 2'b00;
    logic             snap_req = 1'b0;
    logic             snap_ack = 1'b0;
    logic             snap_valid;
    logic [CNT_W-1:0] snap101;
    logic [CNT_W-1:0] snap010;
    logic             alert;
    logic             err;

    pattern_event_counter #(.CNT_W(CNT_W), .THRESHOLD(THRESHOLD)) dut (
        .clock      (clock),
        .reset      (reset),
        .pattern    (pattern),
        .snap_req   (snap_req),
        .snap_ack   (snap_ack),
        .snap_valid (snap_valid),
        .snap101    (snap101),
        .snap010    (snap010),
        .alert      (alert),
        .err        (err)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    int m101 = 0, m010 = 0, ms101 = 0, ms010 = 0;
    bit m_hold = 0, m_err = 0;
    logic [2*CNT_W-1:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int bump(input int v);
`ifdef PEC_SATURATE_EN
        return (v < CMAX) ? v + 1 : v;
`else
        return (v + 1) % (CMAX + 1);
`endif
    endfunction

    // One clock cycle: pattern is captured mid-cycle and counted at the closing edge.
    task automatic step(input logic [1:0] p, input bit req, input bit ack, input bit rst);
        bit clr;
        logic [2*CNT_W-1:0] exp_snap;
        pattern  = p;
        snap_req = req;
        snap_ack = ack;
        reset    = rst;
        @(posedge clock);
        #1;
        clr = 0;
        if (rst) begin
            m101 = 0; m010 = 0; ms101 = 0; ms010 = 0; m_hold = 0; m_err = 0;
        end else begin
            if (p == 2'b11) m_err = 1;
            if (!m_hold && req) begin
                ms101 = m101;
                ms010 = m010;
                m_hold = 1;
                exp_q.push_back({ms101[CNT_W-1:0], ms010[CNT_W-1:0]});
            end else if (m_hold && ack) begin
                clr = 1;
                m_hold = 0;
            end
            if (clr) begin
                m101 = 0;
                m010 = 0;
            end
            if (p == 2'b10) m101 = bump(m101);
            if (p == 2'b01) m010 = bump(m010);
        end
        check("snap_valid", 32'(snap_valid), 32'(m_hold));
        check("snap101", 32'(snap101), ms101);
        check("snap010", 32'(snap010), ms010);
        check("alert", 32'(alert), 32'((m101 + m010) >= THRESHOLD));
        check("err", 32'(err), 32'(m_err));
        check("live101", 32'(dut.live101), m101);
        check("live010", 32'(dut.live010), m010);
        check("state_hold", 32'(dut.state_q == ST_HOLD), 32'(m_hold));
        if (exp_q.size() > 0) begin
            exp_snap = exp_q.pop_front();
            check("snap_pair", 32'({snap101, snap010}), 32'(exp_snap));
        end
    endtask

    initial begin
        step(2'b00, 0, 0, 1);
        step(2'b00, 0, 0, 1);
        check("rst_alert", 32'(alert), 0);

        // basic counting and alert threshold
        step(2'b10, 0, 0, 0);
        step(2'b01, 0, 0, 0);
        step(2'b10, 0, 0, 0);
        step(2'b00, 0, 0, 0);
        check("tp1_live101", 32'(dut.live101), 2);
        check("tp1_live010", 32'(dut.live010), 1);
        check("tp1_alert_lo", 32'(alert), 0);
        step(2'b01, 0, 0, 0);
        check("tp1_alert_hi", 32'(alert), 1);

        // snapshot with a same-cycle event, then ack with a same-cycle event
        step(2'b10, 0, 0, 0);
        step(2'b10, 1, 0, 0);
        check("tp2_snap101", 32'(snap101), 3);
        check("tp2_valid", 32'(snap_valid), 1);
        check("tp2_live101", 32'(dut.live101), 4);
        step(2'b01, 0, 1, 0);
        check("tp2_valid_clr", 32'(snap_valid), 0);
        check("tp2_live101_clr", 32'(dut.live101), 0);
        check("tp2_live010_one", 32'(dut.live010), 1);

        // repeated requests in HOLD leave the snapshot alone
        step(2'b00, 1, 0, 0);
        for (int i = 0; i < 3; i++) step(2'b10, 1, 0, 0);
        check("tp3_snap010", 32'(snap010), 1);
        check("tp3_live101", 32'(dut.live101), 3);
        step(2'b00, 0, 1, 0);

        // illegal code is sticky
        step(2'b11, 0, 0, 0);
        check("tp4_err", 32'(err), 1);
        step(2'b01, 0, 0, 0);
        step(2'b00, 0, 0, 0);
        check("tp4_err_sticky", 32'(err), 1);

        // reset in HOLD beats the event and the ack
        step(2'b00, 1, 0, 0);
        step(2'b10, 0, 1, 1);
        check("tp6_valid", 32'(snap_valid), 0);
        check("tp6_live101", 32'(dut.live101), 0);
        check("tp6_snap101", 32'(snap101), 0);
        check("tp6_err", 32'(err), 0);
        step(2'b00, 0, 0, 0);

        // counter limit: 257 events of one type
        for (int i = 0; i < CMAX + 2; i++) step(2'b10, 0, 0, 0);
`ifdef PEC_SATURATE_EN
        check("tp5_limit", 32'(dut.live101), CMAX);
`else
        check("tp5_limit", 32'(dut.live101), 1);
`endif

        step(2'b00, 0, 0, 1);
        for (int i = 0; i < 600; i++) begin
            step(2'($urandom_range(0, 3)), $urandom_range(0, 3) == 0,
                 $urandom_range(0, 2) == 0, $urandom_range(0, 59) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pattern_event_counter.md
# pattern_event_counter

Downstream consumer of the two-bit Mealy pattern detector output: counts detected `101` and `010` events in separate counters and raises an alert once the combined total reaches a threshold. A request/acknowledge snapshot port hands a frozen copy of both counts to the next stage and clears the live counters. Events are never lost while a snapshot is pending.

## Interface
- `CNT_W`, 8: width of each event counter and snapshot output
- `THRESHOLD`, 4: `alert` asserts when live `cnt101 + cnt010 >= THRESHOLD`; range 1..2^CNT_W

- `clock`  in  1  single clock; all state on rising edge except the capture register (falling edge)
- `reset`  in  1  synchronous, active-high
- `pattern`  in  2  detector output: 2'b10 = `101` seen, 2'b01 = `010` seen, 2'b00 = none, 2'b11 = illegal
- `snap_req`  in  1  level request for a snapshot, sampled on rising edge
- `snap_ack`  in  1  consumer has taken the snapshot, sampled on rising edge
- `snap_valid`  out  1  snapshot outputs are stable and valid
- `snap101`  out  CNT_W  frozen `101` count
- `snap010`  out  CNT_W  frozen `010` count
- `alert`  out  1  live total at or above THRESHOLD
- `err`  out  1  sticky: illegal code 2'b11 was captured

## Operation
- Capture: the detector drives `pattern` valid only from a falling edge to the next rising edge, so `cap` is registered on the falling edge of `clock`. Exactly one capture per cycle.
- Decode on the rising edge:
  - `cap == 2'b10` increments `live101`.
  - `cap == 2'b01` increments `live010`.
  - `cap == 2'b11` sets `err` and leaves both counters unchanged.
- FSM states:
  - RUN: counting. A rising edge with `snap_req=1` copies `live101`/`live010` into `snap101`/`snap010` (values before this cycle's increment), sets `snap_valid`, and moves to HOLD. The cycle's event is still counted into the live counters.
  - HOLD: snapshot outputs frozen and `snap_valid=1`. `snap_req` is ignored and counting continues.
    - `snap_ack=1`: clear `snap_valid` and reset the live counters. If the same cycle carries an event, the counter takes 1 instead of 0. Return to RUN.
- `snap_ack` in RUN is ignored.
- `alert` is registered from the updated live counters each cycle, so it drops together with the clear on ack.
- Reset (rising edge, `reset=1`):
  - Outputs: state RUN, live counters 0, `snap101=snap010=0`, `snap_valid=0`, `alert=0`, `err=0`.
  - Internal: `cap` is cleared on the next falling edge while `reset=1`.
  - Reset in HOLD abandons the snapshot. Reset overrides every simultaneous event, request or ack.

## Timing
- Event latency: `pattern` valid at falling edge N updates the counter and `alert` at the following rising edge, half a cycle later.
- Snapshot: `snap_req` sampled at rising edge k gives `snap_valid=1` after edge k. The minimum HOLD time is one cycle, and an ack at k+1 clears `snap_valid` after k+1.
- Maximum throughput: one event per cycle; one snapshot every 2 cycles.

## Configuration
- `PEC_SATURATE_EN` defined: live counters stop at 2^CNT_W-1, and further events of that type are dropped.
- Not defined: live counters wrap modulo 2^CNT_W. `alert` compares against the wrapped values, so it can deassert after a wrap.

## Structure
- Shared package holds:
  - Code constants `PAT_NONE=2'b00`, `PAT_010=2'b01`, `PAT_101=2'b10`, `PAT_ILLEGAL=2'b11`, which the detector also uses.
  - FSM state encoding `ST_RUN`, `ST_HOLD`.
- One natural sub-module, `event_counter`, instanced twice, one per pattern type.
  - Ports: `clock`, `reset`, `inc`, `clr`, `count`.
  - Honours `PEC_SATURATE_EN`.
  - When `clr` and `inc` are asserted together, the result is 1.

## Test plan
- Reset, then stream `pattern` 10, 01, 10, 00 on successive falling edges → `live101=2`, `live010=1`; `alert=0` at THRESHOLD=4. One more 01 → `alert=1`.
- With `live101=3`, assert `snap_req` in a cycle carrying 2'b10 → `snap101=3`, `snap_valid=1`, live count 4. Ack in a cycle carrying 2'b01 → `snap_valid=0`, `live101=0`, `live010=1`.
- In HOLD, pulse `snap_req` again for 3 cycles with no ack → snapshot values unchanged, live counters keep counting.
- Capture 2'b11 → `err=1`, counters unchanged. `err` stays 1 until `reset`.
- CNT_W=2, five 2'b10 events → saturating build: `live101=3`; wrapping build: `live101=1`.
- Assert `reset` during HOLD with an event and an ack in the same cycle → all outputs 0 and state RUN on the next cycle.
